// File: rtl/i2c_apb_bridge_v2.sv
// rtl/i2c_apb_bridge_v2.sv - APB register bridge to an I2C master: command/TX handshakes, RX FIFO, status, IRQ (option macro: I2C_RX_BACKPRESSURE_EN)
module i2c_apb_bridge_v2 #(
    parameter int          ADDR_WIDTH    = 8,
    parameter int          RX_FIFO_DEPTH = 16,
    parameter logic [15:0] PRESCALE_RST  = 16'd250
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [6:0]            cmd_addr,
    output logic [4:0]            cmd_op,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [8:0]            tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic [8:0]            rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    output logic [15:0]           prescale,
    output logic                  stop_on_idle,
    input  logic                  busy,
    input  logic                  missed_ack,
    output logic                  irq
);
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic             acc, wr_en, rd_en;
    logic [7:0]       offs;
    logic             hit_cmd, hit_addr, hit_pre, hit_tx, hit_rx, hit_stat, hit_ien, hit_ctrl, mapped;
    logic [8:0]       mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic [7:0]       level8;
    logic             rx_empty, rx_full, push_req, push, pop, flush, ovf_set;
    logic             ack_err, rx_ovf;
    logic [2:0]       irq_en;
    logic             stat_wr;
    logic             unused_bits;

    assign acc      = psel & penable;
    assign wr_en    = acc & pwrite;
    assign rd_en    = acc & ~pwrite;
    assign offs     = paddr[7:0];
    assign hit_cmd  = (offs == 8'h00);
    assign hit_addr = (offs == 8'h04);
    assign hit_pre  = (offs == 8'h08);
    assign hit_tx   = (offs == 8'h0C);
    assign hit_rx   = (offs == 8'h10);
    assign hit_stat = (offs == 8'h14);
    assign hit_ien  = (offs == 8'h18);
    assign hit_ctrl = (offs == 8'h1C);
    assign mapped   = hit_cmd | hit_addr | hit_pre | hit_tx | hit_rx | hit_stat | hit_ien | hit_ctrl;
    assign pready   = 1'b1;
    assign pslverr  = acc & (~mapped | (pwrite & hit_cmd & cmd_valid) | (pwrite & hit_tx & tx_tvalid));
    assign unused_bits = ^pwdata[31:16];

    assign rx_empty = (level == '0);
    assign rx_full  = (level == LVL_W'(RX_FIFO_DEPTH));
    assign level8   = 8'(level);
    assign pop      = rd_en & hit_rx & ~rx_empty;
    assign flush    = wr_en & hit_ctrl & pwdata[1];
    assign stat_wr  = wr_en & hit_stat;
    assign push_req = rx_tvalid & rx_tready;

`ifdef I2C_RX_BACKPRESSURE_EN
    // Master is stalled while full, so nothing can ever be lost.
    assign rx_tready = ~rx_full;
    assign push      = push_req & ~flush;
    assign ovf_set   = 1'b0;
`else
    // Always accept; a full FIFO only takes a byte when a pop frees a slot.
    assign rx_tready = 1'b1;
    assign push      = push_req & ~flush & (~rx_full | pop);
    assign ovf_set   = push_req & ~flush & rx_full & ~pop;
`endif

    // Command and TX byte handshakes: load on accepted write, drop on ready.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
        end else begin
            if (wr_en && hit_cmd && !cmd_valid) begin
                cmd_op    <= pwdata[4:0];
                cmd_valid <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (wr_en && hit_tx && !tx_tvalid) begin
                tx_tdata  <= pwdata[8:0];
                tx_tvalid <= 1'b1;
            end else if (tx_tvalid && tx_tready) begin
                tx_tvalid <= 1'b0;
            end
        end
    end

    // Plain configuration registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cmd_addr     <= '0;
            prescale     <= PRESCALE_RST;
            irq_en       <= '0;
            stop_on_idle <= 1'b0;
        end else if (wr_en) begin
            if (hit_addr) cmd_addr     <= pwdata[6:0];
            if (hit_pre)  prescale     <= pwdata[15:0];
            if (hit_ien)  irq_en       <= pwdata[2:0];
            if (hit_ctrl) stop_on_idle <= pwdata[0];
        end
    end

    // RX FIFO pointers and level; flush wins over any same-cycle push.
    always_ff @(posedge pclk) begin
        if (!presetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // RX FIFO storage needs no reset; the level says what is valid.
    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= rx_tdata;
    end

    // Sticky status bits and registered interrupt; a new event beats a W1C.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ack_err <= 1'b0;
            rx_ovf  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ack_err <= missed_ack | (ack_err & ~(stat_wr & pwdata[1]));
            rx_ovf  <= ovf_set | (rx_ovf & ~(stat_wr & pwdata[4]));
            irq     <= |(irq_en & {rx_ovf, ack_err, ~rx_empty});
        end
    end

    // Read mux, driven only during a read access phase.
    always_comb begin
        prdata = 32'h0;
        if (rd_en) begin
            case (offs)
                8'h00: prdata = {23'b0, cmd_valid, 3'b0, cmd_op};
                8'h04: prdata = {25'b0, cmd_addr};
                8'h08: prdata = {16'b0, prescale};
                8'h0C: prdata = {23'b0, tx_tdata};
                8'h10: prdata = rx_empty ? 32'h0 : {22'b0, 1'b1, mem[rd_ptr]};
                8'h14: prdata = {16'b0, level8, 1'b0, tx_tvalid, cmd_valid, rx_ovf,
                                 rx_full, rx_empty, ack_err, busy};
                8'h18: prdata = {29'b0, irq_en};
                8'h1C: prdata = {31'b0, stop_on_idle};
                default: prdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_apb_bridge_v2.sv
// tb/tb_i2c_apb_bridge_v2.sv - directed self-checking bench for i2c_apb_bridge_v2
module tb_i2c_apb_bridge_v2;
    logic        pclk, presetn;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [6:0]  cmd_addr;
    logic [4:0]  cmd_op;
    logic        cmd_valid, cmd_ready;
    logic [8:0]  tx_tdata;
    logic        tx_tvalid, tx_tready;
    logic [8:0]  rx_tdata;
    logic        rx_tvalid, rx_tready;
    logic [15:0] prescale;
    logic        stop_on_idle, busy, missed_ack, irq;

    int errors = 0;
    int checks = 0;
    logic [8:0]  model_q[$];
    logic [31:0] rd;
    logic        err;

    i2c_apb_bridge_v2 dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .cmd_addr(cmd_addr), .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .prescale(prescale), .stop_on_idle(stop_on_idle), .busy(busy),
        .missed_ack(missed_ack), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        #1 e = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic with_push, input logic [8:0] pd,
                            output logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        if (with_push) begin
            rx_tdata = pd; rx_tvalid = 1'b1;
        end
        #1 d = prdata; e = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; rx_tvalid = 1'b0;
    endtask

    task automatic rx_push(input logic [8:0] d);
        rx_tdata = d; rx_tvalid = 1'b1;
        tick();
        rx_tvalid = 1'b0;
    endtask

    initial begin
        presetn = 1'b0; paddr = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0;
        cmd_ready = 0; tx_tready = 0; rx_tdata = '0; rx_tvalid = 0; busy = 0; missed_ack = 0;
        repeat (3) tick();
        presetn = 1'b1;
        tick();

        // Reset state
        check("rst_prescale", 32'(prescale), 32'd250);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("rst_status", rd, 32'h0004);

        // Command handshake with stalled ready
        apb_write(8'h00, 32'h21, err);
        check("cmd_wr_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("cmd_hold_valid", 32'(cmd_valid), 32'd1);
            check("cmd_hold_op", 32'(cmd_op), 32'h01);
            tick();
        end
        apb_write(8'h00, 32'h05, err);
        check("cmd_rewrite_err", 32'(err), 32'd1);
        check("cmd_op_kept", 32'(cmd_op), 32'h01);
        apb_read(8'h00, 1'b0, 9'h0, rd, err);
        check("cmd_read", rd, 32'h101);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("cmd_done", 32'(cmd_valid), 32'd0);

        // TX byte handshake
        apb_write(8'h0C, 32'h1FF, err);
        check("tx_wr_err", 32'(err), 32'd0);
        check("tx_tvalid", 32'(tx_tvalid), 32'd1);
        apb_write(8'h0C, 32'h012, err);
        check("tx_rewrite_err", 32'(err), 32'd1);
        check("tx_tdata_kept", 32'(tx_tdata), 32'h1FF);
        tx_tready = 1'b1;
        tick();
        tx_tready = 1'b0;
        check("tx_done", 32'(tx_tvalid), 32'd0);

        // Config registers and unmapped offsets
        apb_write(8'h04, 32'hD5, err);
        check("cmd_addr", 32'(cmd_addr), 32'h55);
        apb_write(8'h08, 32'h1234, err);
        check("prescale_out", 32'(prescale), 32'h1234);
        apb_read(8'h20, 1'b0, 9'h0, rd, err);
        check("unmapped_rd_err", 32'(err), 32'd1);
        check("unmapped_rd_data", rd, 32'h0);
        apb_write(8'h24, 32'hFFFF, err);
        check("unmapped_wr_err", 32'(err), 32'd1);

        // RX single byte, then empty read
        rx_push(9'h1A5);
        apb_read(8'h10, 1'b0, 9'h0, rd, err);
        check("rx_read", rd, 32'h3A5);
        apb_read(8'h10, 1'b0, 9'h0, rd, err);
        check("rx_empty_read", rd, 32'h0);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("status_empty", rd, 32'h0004);

        // Missed ACK sticky and W1C
        missed_ack = 1'b1;
        tick();
        missed_ack = 1'b0;
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("ack_err_set", rd, 32'h0006);
        apb_write(8'h14, 32'h2, err);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("ack_err_clr", rd, 32'h0004);

        // Fill FIFO (pointers start at 1, so this wraps)
        for (int i = 0; i < 16; i++) begin
            logic [8:0] v;
            v = {i[0], 8'(8'h40 + i)};
            rx_push(v);
            model_q.push_back(v);
        end
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("status_full", rd, 32'h1008);
        apb_write(8'h18, 32'h4, err);
`ifdef I2C_RX_BACKPRESSURE_EN
        check("bp_tready", 32'(rx_tready), 32'd0);
        rx_push(9'h0AA);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("bp_no_ovf", rd, 32'h1008);
`else
        rx_push(9'h0AA);
        check("ovf_irq_lag", 32'(irq), 32'd0);
        tick();
        check("ovf_irq", 32'(irq), 32'd1);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("status_ovf", rd, 32'h1018);
        apb_write(8'h14, 32'h10, err);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("ovf_clr", rd, 32'h1008);
        check("irq_clr", 32'(irq), 32'd0);
        // Push and pop together while full
        apb_read(8'h10, 1'b1, 9'h0BB, rd, err);
        check("full_pushpop_rd", rd, {22'b0, 1'b1, model_q.pop_front()});
        model_q.push_back(9'h0BB);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("full_pushpop_status", rd, 32'h1008);
`endif
        for (int i = 0; i < 16; i++) begin
            apb_read(8'h10, 1'b0, 9'h0, rd, err);
            check("drain_order", rd, {22'b0, 1'b1, model_q.pop_front()});
        end
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("drained_status", rd, 32'h0004);

        // Flush and CTRL readback
        rx_push(9'h011);
        rx_push(9'h022);
        apb_write(8'h1C, 32'h3, err);
        check("stop_on_idle", 32'(stop_on_idle), 32'd1);
        apb_read(8'h14, 1'b0, 9'h0, rd, err);
        check("flush_status", rd, 32'h0004);
        apb_read(8'h1C, 1'b0, 9'h0, rd, err);
        check("ctrl_read", rd, 32'h1);

        // Non-empty interrupt
        apb_write(8'h18, 32'h1, err);
        rx_push(9'h033);
        check("rx_irq_lag", 32'(irq), 32'd0);
        tick();
        check("rx_irq", 32'(irq), 32'd1);

        // Reset mid-handshake abandons the command
        apb_write(8'h00, 32'h03, err);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        check("rst_abandon_cmd", 32'(cmd_valid), 32'd0);
        check("rst_irq_again", 32'(irq), 32'd0);
        check("rst_prescale_again", 32'(prescale), 32'd250);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
